// File: rtl/spi_xip_cache_ahbl.sv
// spi_xip_cache_ahbl
//   Read-only AHB-Lite slave giving execute-in-place access to a single-bit
//   SPI NOR flash (command 0x03). A direct-mapped line cache fronts the flash:
//   hits complete with zero wait states, misses stall while a whole line is
//   fetched over SPI.
// Ports
//   HCLK, HRESETn            : clock, async active-low reset
//   HSEL/HADDR/HTRANS/HWRITE/HREADY : AHB-Lite address phase
//   HREADYOUT, HRDATA        : AHB-Lite data phase response
//   sck, ce_n, mosi, miso    : SPI mode-0 flash pins, sck = HCLK/2
module spi_xip_cache_ahbl #(
  parameter int NUM_LINES = 16,
  parameter int LINE_SIZE = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        sck,
  output logic        ce_n,
  input  logic        miso,
  output logic        mosi
);
  localparam int OFF_W  = $clog2(LINE_SIZE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 24 - OFF_W - IDX_W;
  localparam int WPL    = LINE_SIZE / 4;
  localparam int WI_W   = (OFF_W > 2) ? OFF_W - 2 : 1;
  localparam int LINE_W = LINE_SIZE * 8;
  localparam int CNT_W  = $clog2(LINE_W);

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(23);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(LINE_W - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

  // data-phase request captured at the address phase
  typedef struct packed {
    logic        rd;
    logic [23:0] addr;
  } req_t;

  req_t                              dp;
  state_t                            state, state_nx;
  logic [NUM_LINES-1:0]              valid;
  logic [NUM_LINES-1:0][TAG_W-1:0]   tags;
  logic [NUM_LINES-1:0][WPL-1:0][31:0] line_data;

  logic [IDX_W-1:0]  dp_idx;
  logic [TAG_W-1:0]  dp_tag;
  logic [OFF_W-1:0]  boff;
  logic [WI_W-1:0]   word_idx;
  logic              hit, miss;

  logic              ph;     // 0: sck low half of a bit, 1: sck high half
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       tx_sh;
  logic [LINE_W-1:0] rx_sh;
  logic [LINE_SIZE-1:0][7:0] fill_bytes;
  logic              unused_hi;

  assign unused_hi = ^HADDR[31:24];

  // ---------------- AHB address/data phase ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp <= '0;
    end else if (HREADY) begin
      dp.rd   <= HSEL & HTRANS[1] & ~HWRITE;
      dp.addr <= HADDR[23:0];
    end
  end

  assign dp_idx   = dp.addr[OFF_W +: IDX_W];
  assign dp_tag   = dp.addr[23 -: TAG_W];
  assign boff     = dp.addr[OFF_W-1:0];
  assign word_idx = WI_W'(boff >> 2);

  assign hit  = valid[dp_idx] && (tags[dp_idx] == dp_tag);
  assign miss = dp.rd & ~hit;

  // A miss holds the bus until DONE installs the line; the following cycle
  // turns into a hit and returns the word.
  assign HREADYOUT = ~miss;
  assign HRDATA    = (dp.rd && hit) ? line_data[dp_idx][word_idx] : 32'h0;

  // ---------------- fill FSM ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (miss)                     state_nx = CMD;
      CMD:  if (ph && cnt == CMD_LAST)    state_nx = ADDR;
      ADDR: if (ph && cnt == ADDR_LAST)   state_nx = DATA;
      DATA: if (ph && cnt == DATA_LAST)   state_nx = DONE;
      DONE:                               state_nx = IDLE;
      default:                            state_nx = IDLE;
    endcase
  end

  always_comb begin
    ce_n = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    case (state)
      CMD, ADDR: begin
        ce_n = 1'b0;
        sck  = ph;
        mosi = tx_sh[31];
      end
      DATA: begin
        ce_n = 1'b0;
        sck  = ph;
      end
      default: ;
    endcase
  end

  // ---------------- SPI shifters ----------------
  // sck rises on the edge leaving ph=0, so miso is captured on that edge;
  // mosi advances on the edge leaving ph=1, i.e. as sck falls.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ph    <= 1'b0;
      cnt   <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
    end else if (state == IDLE) begin
      ph    <= 1'b0;
      cnt   <= '0;
      tx_sh <= {8'h03, dp_tag, dp_idx, {OFF_W{1'b0}}};
    end else if (state != DONE) begin
      ph <= ~ph;
      if (!ph && state == DATA) rx_sh <= {rx_sh[LINE_W-2:0], miso};
      if (ph) begin
        tx_sh <= {tx_sh[30:0], 1'b0};
        cnt   <= (state_nx != state) ? '0 : cnt + 1'b1;
      end
    end
  end

  // First received byte sits at the top of rx_sh; it belongs at line byte 0.
  always_comb begin
    fill_bytes = '0;
    for (int k = 0; k < LINE_SIZE; k++)
      fill_bytes[k] = rx_sh[(LINE_SIZE-1-k)*8 +: 8];
  end

  // ---------------- cache arrays ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid <= '0;
      tags  <= '0;
    end else if (state == DONE) begin
      valid[dp_idx] <= 1'b1;
      tags[dp_idx]  <= dp_tag;
    end
  end

  always_ff @(posedge HCLK) begin
    if (state == DONE) line_data[dp_idx] <= fill_bytes;
  end

endmodule

// File: tb/tb_spi_xip_cache_ahbl.sv
module tb_spi_xip_cache_ahbl;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        sck, ce_n, miso, mosi;

  int tests = 0;
  int fails = 0;

  assign HREADY = HREADYOUT;

  spi_xip_cache_ahbl #(.NUM_LINES(16), .LINE_SIZE(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .sck(sck), .ce_n(ce_n), .miso(miso), .mosi(mosi)
  );

  always #5 HCLK = ~HCLK;

  // ---------------- flash model (mode 0, cmd 0x03) ----------------
  logic [7:0]  mem [0:1023];
  logic [31:0] in_sh;
  logic [31:0] last_cmd;
  int          fbit = 0;
  int          sck_cnt = 0;
  int          ce_falls = 0;
  int          mosi_err = 0;

  always @(posedge sck) begin
    sck_cnt++;
    if (!ce_n) begin
      if (fbit < 32) begin
        in_sh = {in_sh[30:0], mosi};
        if (fbit == 31) last_cmd = in_sh;
      end else if (mosi !== 1'b0) begin
        mosi_err++;
      end
      fbit++;
    end
  end

  always @(negedge sck) begin
    if (!ce_n && fbit >= 32) begin
      int a;
      a = (int'(in_sh[23:0]) + (fbit - 32) / 8) & 1023;
      miso = mem[a][7 - ((fbit - 32) % 8)];
    end
  end

  always @(ce_n) if (ce_n === 1'b1) fbit = 0;
  always @(negedge ce_n) ce_falls++;

  // ---------------- bus helper ----------------
  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d, output int w);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    w = 0;
    while (!HREADYOUT && w < 400) begin
      @(negedge HCLK);
      w++;
    end
    d = HRDATA;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    HRESETn = 1'b0; HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; miso = 0;
    repeat (3) @(negedge HCLK);
    tests++; if (HREADYOUT !== 1'b1) begin fails++; $display("FAIL reset_hreadyout got %b want 1", HREADYOUT); end
    tests++; if (HRDATA !== 32'h0) begin fails++; $display("FAIL reset_hrdata got %h want 0", HRDATA); end
    tests++; if ({sck, ce_n, mosi} !== 3'b010) begin fails++; $display("FAIL reset_spi sck/ce_n/mosi got %b want 010", {sck, ce_n, mosi}); end
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_first_miss();
    logic [31:0] d; int w; int s0, c0;
    s0 = sck_cnt; c0 = ce_falls; last_cmd = 'x; mosi_err = 0;
    ahb_read(32'h0, d, w);
    tests++; if (ce_falls !== c0 + 1) begin fails++; $display("FAIL miss0_ce_fall got %0d want %0d", ce_falls - c0, 1); end
    tests++; if (last_cmd !== 32'h0300_0000) begin fails++; $display("FAIL miss0_cmd got %h want 03000000", last_cmd); end
    tests++; if (sck_cnt - s0 !== 160) begin fails++; $display("FAIL miss0_sck_pulses got %0d want 160", sck_cnt - s0); end
    tests++; if (w < 320 || w > 324) begin fails++; $display("FAIL miss0_waits got %0d want 320..324", w); end
    tests++; if (d !== 32'h0302_0100) begin fails++; $display("FAIL miss0_data got %h want 03020100", d); end
    tests++; if (ce_n !== 1'b1) begin fails++; $display("FAIL miss0_ce_release got %b want 1", ce_n); end
    tests++; if (mosi_err !== 0) begin fails++; $display("FAIL miss0_mosi_data_phase got %0d want 0", mosi_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2; logic r1, r2; int s0;
    s0 = sck_cnt;
    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h4;
    @(posedge HCLK); @(negedge HCLK);
    r1 = HREADYOUT; d1 = HRDATA;
    HADDR = 32'h8;
    @(posedge HCLK); @(negedge HCLK);
    r2 = HREADYOUT; d2 = HRDATA;
    HSEL = 0; HTRANS = 0;
    tests++; if ({r1, r2} !== 2'b11) begin fails++; $display("FAIL b2b_ready got %b want 11", {r1, r2}); end
    tests++; if (d1 !== 32'h0706_0504) begin fails++; $display("FAIL b2b_word1 got %h want 07060504", d1); end
    tests++; if (d2 !== 32'h0B0A_0908) begin fails++; $display("FAIL b2b_word2 got %h want 0b0a0908", d2); end
    tests++; if (sck_cnt !== s0) begin fails++; $display("FAIL b2b_no_sck got %0d want 0", sck_cnt - s0); end
  endtask

  task automatic test_second_line();
    logic [31:0] d; int w;
    ahb_read(32'h10, d, w);
    tests++; if (last_cmd !== 32'h0300_0010) begin fails++; $display("FAIL line1_cmd got %h want 03000010", last_cmd); end
    tests++; if (d !== 32'h1312_1110) begin fails++; $display("FAIL line1_data got %h want 13121110", d); end
    ahb_read(32'h1C, d, w);
    tests++; if (w !== 0) begin fails++; $display("FAIL line1_hit_waits got %0d want 0", w); end
    tests++; if (d !== 32'h1F1E_1D1C) begin fails++; $display("FAIL line1_hit_data got %h want 1f1e1d1c", d); end
  endtask

  task automatic test_conflict();
    logic [31:0] d; int w;
    ahb_read(32'h100, d, w);
    tests++; if (w < 320) begin fails++; $display("FAIL conf_miss_waits got %0d want >=320", w); end
    tests++; if (last_cmd !== 32'h0300_0100) begin fails++; $display("FAIL conf_cmd got %h want 03000100", last_cmd); end
    tests++; if (d !== 32'hA3A2_A1A0) begin fails++; $display("FAIL conf_data got %h want a3a2a1a0", d); end
    ahb_read(32'h0, d, w);
    tests++; if (w < 320) begin fails++; $display("FAIL conf_refill_waits got %0d want >=320", w); end
    tests++; if (d !== 32'h0302_0100) begin fails++; $display("FAIL conf_refill_data got %h want 03020100", d); end
  endtask

  task automatic test_write_idle();
    logic [31:0] d; int w; int c0;
    c0 = ce_falls;
    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h0;
    @(posedge HCLK); @(negedge HCLK);
    HTRANS = 2'b00; HWRITE = 0;
    tests++; if ({HREADYOUT, ce_n} !== 2'b11) begin fails++; $display("FAIL write_ready_ce got %b want 11", {HREADYOUT, ce_n}); end
    @(posedge HCLK); @(negedge HCLK);
    tests++; if ({HREADYOUT, ce_n} !== 2'b11) begin fails++; $display("FAIL idle_ready_ce got %b want 11", {HREADYOUT, ce_n}); end
    HSEL = 0;
    repeat (3) @(negedge HCLK);
    tests++; if (ce_falls !== c0) begin fails++; $display("FAIL write_idle_no_fill got %0d want 0", ce_falls - c0); end
    ahb_read(32'h0, d, w);
    tests++; if (w !== 0) begin fails++; $display("FAIL post_write_hit_waits got %0d want 0", w); end
    tests++; if (d !== 32'h0302_0100) begin fails++; $display("FAIL post_write_data got %h want 03020100", d); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d; int w;
    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h200;
    @(posedge HCLK); @(negedge HCLK);
    HSEL = 0; HTRANS = 0;
    repeat (60) @(negedge HCLK);
    tests++; if (ce_n !== 1'b0) begin fails++; $display("FAIL midfill_active got ce_n=%b want 0", ce_n); end
    @(posedge HCLK); #2;
    HRESETn = 1'b0;
    #1;
    tests++; if ({ce_n, sck, HREADYOUT} !== 3'b101) begin fails++; $display("FAIL midfill_reset ce_n/sck/ready got %b want 101", {ce_n, sck, HREADYOUT}); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    ahb_read(32'h0, d, w);
    tests++; if (w < 320 || w > 324) begin fails++; $display("FAIL after_reset_waits got %0d want 320..324", w); end
    tests++; if (last_cmd !== 32'h0300_0000) begin fails++; $display("FAIL after_reset_cmd got %h want 03000000", last_cmd); end
    tests++; if (d !== 32'h0302_0100) begin fails++; $display("FAIL after_reset_data got %h want 03020100", d); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int i = 0; i < 32; i++)   mem[i] = 8'(i);
    for (int i = 0; i < 4; i++)    mem[256 + i] = 8'hA0 + 8'(i);
    test_reset();
    test_first_miss();
    test_back_to_back();
    test_second_line();
    test_conflict();
    test_write_idle();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_xip_cache_ahbl.md
Name: spi_xip_cache_ahbl

Overview:
- Read-only AHB-Lite slave providing execute-in-place access to an external single-bit SPI NOR flash (SST26WF080B-class, standard read command 0x03).
- A small direct-mapped line cache fronts the flash. Hits complete with zero wait states; misses stall the bus while a full line is fetched over SPI.
- Sits on the AHB-Lite instruction/data bus between the CPU fabric and the flash pins.

Parameters:
- NUM_LINES, 16, number of cache lines (power of 2).
- LINE_SIZE, 16, bytes per line (power of 2, ≥4).

Ports:
- HCLK  in  1  bus clock; sole clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; bits [23:0] form the flash address.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HWRITE  in  1  write flag; writes are ignored.
- HREADY  in  1  bus ready, for address-phase qualification.
- HREADYOUT  out  1  slave ready; 0 inserts wait states.
- HRDATA  out  32  read data.
- sck  out  1  SPI clock, mode 0.
- ce_n  out  1  flash chip enable, active-low.
- miso  in  1  flash serial data out.
- mosi  out  1  serial data to flash.

Behaviour:
- Reset values: HREADYOUT=1, HRDATA=0, sck=0, ce_n=1, mosi=0. All line valid bits are cleared and the FSM is IDLE.
- Address split for defaults:
  - word offset = HADDR[3:2]
  - index = HADDR[7:4]
  - tag = HADDR[23:8]
  - HADDR[31:24] is ignored.
- Address phase: a transfer is accepted when HSEL & HTRANS[1] & HREADY. The controller registers the address and a read flag (~HWRITE).
- Data phase, hit (valid[index] and tag match):
  - HREADYOUT=1 in the first data-phase cycle.
  - HRDATA = selected word of the line.
- Data phase, miss:
  - HREADYOUT=0 until the line fill completes.
  - The cycle after the fill completes, HREADYOUT=1 and HRDATA carries the requested word.
- Writes and idle/busy transfers: HREADYOUT stays 1, no cache or flash activity, HRDATA is don't-care.
- Fill FSM states and transitions:
  - IDLE → on miss, assert ce_n=0 → CMD.
  - CMD: shift out 8 bits of 0x03.
  - ADDR: shift out 24-bit line-aligned address ({tag,index,4'b0}).
  - DATA: shift in LINE_SIZE*8 bits.
  - DONE: ce_n=1, sck=0; write line data, tag and valid=1 → IDLE.
- SPI timing:
  - sck = HCLK/2; each bit takes 2 HCLK cycles.
  - mosi changes while sck is low; MSB first.
  - miso is sampled on the sck rising edge.
  - mosi = 0 during DATA.
- Byte packing: byte at flash address A goes to line byte (A mod LINE_SIZE). Words are little-endian: byte A+0 → HRDATA[7:0], … A+3 → HRDATA[31:24].
- Fill latency: 8+24+128 = 160 bits = 320 HCLK cycles of sck activity plus ≤4 cycles overhead. HREADYOUT is low for ≤324 cycles.
- Only one fill is outstanding at a time; a new address phase cannot be accepted while HREADYOUT=0.
- Replacement: the indexed line is overwritten unconditionally. There is no write-back, since the cache is read-only.
- Back-to-back transfers: the address phase of the next transfer is accepted in the same cycle the current data phase completes. A hit followed by a hit gives one word per cycle.
- Reset mid-fill: ce_n returns to 1 and sck to 0 immediately. The partial line is discarded and valid bits are cleared.
- No error response; the block has no HRESP port.

Test Plan:
- Preload flash bytes 0x00..0x1F with value = address, plus byte 0x100..0x103 = 0xA0..0xA3. Release reset, then read 0x0:
  - ce_n falls.
  - mosi carries 0x03 followed by 0x000000.
  - 160 sck pulses occur.
  - HREADYOUT is low ≤324 cycles.
  - HRDATA = 0x03020100.
  - ce_n returns to 1.
- Read 0x4 then 0x8 → zero wait states, no sck activity, HRDATA = 0x07060504 then 0x0B0A0908.
- Read 0x10 → miss with address 0x000010 on mosi, HRDATA = 0x13121110. A following read of 0x1C is a hit = 0x1F1E1D1C.
- Conflict: read 0x100 (index 0, tag 1) → miss, HRDATA = 0xA3A2A1A0. Then read 0x0 → miss again, 0x03020100.
- Write to 0x0 and an IDLE HTRANS with HSEL=1 → HREADYOUT stays 1, ce_n stays 1, and the cache is unaffected (a subsequent read of 0x0 after the 0x0 refill is still a hit).
- Assert HRESETn=0 mid-fill → ce_n=1, sck=0, HREADYOUT=1 immediately. After release, read 0x0 → full miss fill and the correct data.
